acalu_arb: RTL and testbench
============================

# acalu_arb

Two-requester arbiter and sequencer for the shared 4-bit combinational ALU (ops: add, sub, not, and, or, xor, signed-less-than flag, zero/equal flag). Accepts one operation at a time from either requester via valid/ready, drives the ALU from registered operands, captures result and flag, and returns them on a single tagged response channel. Sits between the two client blocks and the ALU instance.

## Interface
- `ALU_W`, 4, operand/result width
- `OP_W`, 3, ALU control width
- `clk` in 1: clock, rising edge
- `rst_n` in 1: asynchronous active-low reset
- `req_valid` in 2: per-requester request valid, bit i = requester i
- `req_ready` out 2: per-requester accept, one-hot or zero
- `req0_x0`, `req0_x1` / `req1_x0`, `req1_x1` in ALU_W each: operands
- `req0_op` / `req1_op` in OP_W: ALU control code 0..7
- `alu_x0`, `alu_x1` out ALU_W: to ALU
- `alu_ctr` out OP_W: to ALU
- `alu_result` in ALU_W, `alu_flg` in 1: from ALU, combinational
- `rsp_valid` out 1: response valid
- `rsp_ready` in 1: response consumer ready
- `rsp_id` out 1: requester that owns the response
- `rsp_result` out ALU_W, `rsp_flg` out 1: captured ALU outputs

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state IDLE.
- IDLE: if any `req_valid` bit set, compute grant; `req_ready[g]`=1 combinationally for granted g only; on that cycle latch x0/x1/op of g and `g` into operand regs; next EXEC. No valid → stay IDLE, `req_ready`=0.
- EXEC: `alu_*` driven from operand regs; capture `alu_result`, `alu_flg` into response regs at end of cycle; next RESP.
- RESP: `rsp_valid`=1, `rsp_id`/`rsp_result`/`rsp_flg` held stable; when `rsp_ready`=1 → IDLE; else stay (backpressure, no new accepts).
- `req_ready`=0 outside IDLE. Requesters hold valid and payload stable until ready; dropping valid before ready is legal and simply withdraws the request.
- ALU result semantics pass through unchanged: ops 0-5 give `rsp_flg`=0; ops 6-7 give `rsp_result`=0.
- `alu_*` always driven from operand regs (hold last operation between ops).
- Reset values: `req_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_result`=0, `rsp_flg`=0, `alu_x0`=`alu_x1`=0, `alu_ctr`=0, grant pointer last=1.
- Reset mid-operation (EXEC or RESP): return to IDLE immediately, in-flight op discarded, no response issued.

## Timing
- Accept in cycle N (valid&ready) → EXEC in N+1 → `rsp_valid` high from N+2.
- Response fires cycle M (rsp_valid&rsp_ready) → IDLE in M+1; earliest next accept M+1.
- Max throughput: one op per 3 cycles with `rsp_ready` tied high.
- `req_ready` is combinational from `req_valid` and state; no combinational path from `rsp_ready` or `alu_*` to any output.

## Configuration
- `ACALU_ARB_RR_EN` defined: round-robin. Both valid in IDLE → grant requester ≠ last granted; pointer updated on every accept. Single valid → that one granted.
- Undefined: fixed priority, requester 0 always wins when both valid; pointer logic absent.

## Structure
- `acalu_pkg`: ALU op code constants (OP_ADD=0 … OP_EQ=7), FSM state typedef, ALU_W/OP_W defaults.
- One sub-module: `acalu_arb_grant` — 2-way grant logic (round-robin pointer under macro, fixed priority otherwise), outputs one-hot grant.
- ALU stays external; arbiter only drives/samples its ports.

## Test plan
- Req0 only: x0=3, x1=5, op=0 → accepted cycle N, `rsp_valid` at N+2, `rsp_id`=0, result=8, flg=0.
- Req1 only: x0=4'b1000, x1=1, op=6 → `rsp_id`=1, result=0, flg=1; then x0=x1=9, op=7 → result=0, flg=1.
- Both valid continuously, `rsp_ready`=1, RR_EN defined → grants alternate 0,1,0,1; undefined → four grants all to 0.
- `rsp_ready` held low 5 cycles in RESP → `rsp_*` stable, `req_ready`=0 throughout; release → IDLE next cycle, next accept then.
- Assert `rst_n` low during EXEC of op 5 (x0=6, x1=3) → `rsp_valid` never rises, all outputs at reset values, post-reset first request served normally.
- Req0 drops valid before grant while req1 valid → req1 granted, no spurious accept of req0.

Source files
------------

// File: rtl/acalu_pkg.sv
// Shared definitions for the ALU arbiter: op codes, FSM states, default widths.
// Build option: ACALU_ARB_RR_EN selects round-robin arbitration (else fixed priority).
package acalu_pkg;

    localparam int ALU_W_DEF = 4;
    localparam int OP_W_DEF  = 3;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_NOT = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_OR  = 3'd4;
    localparam logic [2:0] OP_XOR = 3'd5;
    localparam logic [2:0] OP_SLT = 3'd6;
    localparam logic [2:0] OP_EQ  = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/acalu_arb_grant.sv
// 2-way one-hot grant; combinational from req, zero latency, no backpressure of its own.
// ACALU_ARB_RR_EN: round-robin on a last-granted pointer; otherwise requester 0 has priority.
module acalu_arb_grant (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       acc,
    output logic [1:0] gnt
);

`ifdef ACALU_ARB_RR_EN
    logic last;

    // last names the requester granted most recently; reset favours requester 0 first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last <= 1'b1;
        else if (acc)
            last <= gnt[1];
    end

    always_comb begin
        gnt = req;
        if (req == 2'b11)
            gnt = last ? 2'b01 : 2'b10;
    end
`else
    logic unused_in;
    assign unused_in = clk ^ rst_n ^ acc;

    always_comb begin
        gnt = req;
        if (req[0])
            gnt = 2'b01;
    end
`endif

endmodule

// File: rtl/acalu_arb.sv
// Arbitrates two requesters onto one external 4-bit ALU; accept->rsp_valid 2 cycles, one op per 3 cycles max.
// Holds the response until rsp_ready; no new accepts until it drains. ACALU_ARB_RR_EN selects round-robin.
module acalu_arb
    import acalu_pkg::*;
#(
    parameter int ALU_W = ALU_W_DEF,
    parameter int OP_W  = OP_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [ALU_W-1:0] req0_x0,
    input  logic [ALU_W-1:0] req0_x1,
    input  logic [OP_W-1:0]  req0_op,
    input  logic [ALU_W-1:0] req1_x0,
    input  logic [ALU_W-1:0] req1_x1,
    input  logic [OP_W-1:0]  req1_op,
    output logic [ALU_W-1:0] alu_x0,
    output logic [ALU_W-1:0] alu_x1,
    output logic [OP_W-1:0]  alu_ctr,
    input  logic [ALU_W-1:0] alu_result,
    input  logic             alu_flg,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [ALU_W-1:0] rsp_result,
    output logic             rsp_flg
);

    state_t           state, nxt;
    logic [1:0]       gnt;
    logic             acc;
    logic [ALU_W-1:0] x0_q, x1_q;
    logic [OP_W-1:0]  ctr_q;
    logic             id_q;

    acalu_arb_grant u_grant (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req_valid),
        .acc   (acc),
        .gnt   (gnt)
    );

    // Gated by rst_n so ready reads zero while reset is held, even with valid asserted
    assign req_ready = (state == ST_IDLE && rst_n) ? gnt : 2'b00;
    assign acc       = |req_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE: if (acc)       nxt = ST_EXEC;
            ST_EXEC:                nxt = ST_RESP;
            ST_RESP: if (rsp_ready) nxt = ST_IDLE;
            default:                nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x0_q  <= '0;
            x1_q  <= '0;
            ctr_q <= '0;
            id_q  <= 1'b0;
        end else if (acc) begin
            x0_q  <= gnt[1] ? req1_x0 : req0_x0;
            x1_q  <= gnt[1] ? req1_x1 : req0_x1;
            ctr_q <= gnt[1] ? req1_op : req0_op;
            id_q  <= gnt[1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_result <= '0;
            rsp_flg    <= 1'b0;
            rsp_id     <= 1'b0;
        end else if (state == ST_EXEC) begin
            rsp_result <= alu_result;
            rsp_flg    <= alu_flg;
            rsp_id     <= id_q;
        end
    end

    assign alu_x0    = x0_q;
    assign alu_x1    = x1_q;
    assign alu_ctr   = ctr_q;
    assign rsp_valid = (state == ST_RESP);

endmodule

// File: tb/tb_acalu_arb.sv
// Directed plus randomized bench for acalu_arb with a behavioural ALU and arbitration model.
module tb_acalu_arb;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [3:0] req0_x0, req0_x1, req1_x0, req1_x1;
    logic [2:0] req0_op, req1_op;
    logic [3:0] alu_x0, alu_x1, alu_result;
    logic [2:0] alu_ctr;
    logic       alu_flg;
    logic       rsp_valid, rsp_ready, rsp_id, rsp_flg;
    logic [3:0] rsp_result;

    int   checks = 0;
    int   errors = 0;
    logic last_g = 1'b1;

    always #5 clk = ~clk;

    acalu_arb #(.ALU_W(4), .OP_W(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req0_x0    (req0_x0),
        .req0_x1    (req0_x1),
        .req0_op    (req0_op),
        .req1_x0    (req1_x0),
        .req1_x1    (req1_x1),
        .req1_op    (req1_op),
        .alu_x0     (alu_x0),
        .alu_x1     (alu_x1),
        .alu_ctr    (alu_ctr),
        .alu_result (alu_result),
        .alu_flg    (alu_flg),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_flg    (rsp_flg)
    );

    // Behavioural ALU: returns {flag, result} from plain integer arithmetic
    function automatic logic [4:0] alu_ref(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        int ia, ib, sa, sb, r;
        ia = int'(a);
        ib = int'(b);
        sa = (ia > 7) ? ia - 16 : ia;
        sb = (ib > 7) ? ib - 16 : ib;
        r  = 0;
        case (op)
            3'd0: r = (ia + ib) % 16;
            3'd1: r = (ia - ib + 16) % 16;
            3'd2: r = 15 - ia;
            3'd3: r = int'(a & b);
            3'd4: r = int'(a | b);
            3'd5: r = int'(a ^ b);
            3'd6: r = (sa < sb) ? 16 : 0;
            default: r = (ia == ib) ? 16 : 0;
        endcase
        return r[4:0];
    endfunction

    always_comb {alu_flg, alu_result} = alu_ref(alu_ctr, alu_x0, alu_x1);

    function automatic logic exp_grant(input logic [1:0] v);
`ifdef ACALU_ARB_RR_EN
        if (v == 2'b11)
            return !last_g;
`endif
        return v[0] ? 1'b0 : 1'b1;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT in IDLE; returns at the negedge after the response fires.
    task automatic do_op(input logic [1:0] v,
                         input logic [3:0] a0, input logic [3:0] a1, input logic [2:0] o0,
                         input logic [3:0] b0, input logic [3:0] b1, input logic [2:0] o1,
                         input logic [1:0] pend, input int hold);
        logic       g;
        logic [3:0] ex0, ex1;
        logic [2:0] eo;
        logic [4:0] r;
        req_valid = v;
        req0_x0 = a0; req0_x1 = a1; req0_op = o0;
        req1_x0 = b0; req1_x1 = b1; req1_op = o1;
        #1;
        g = exp_grant(v);
        check("accept_ready", {6'd0, req_ready}, g ? 8'd2 : 8'd1);
        last_g = g;
        ex0 = g ? b0 : a0;
        ex1 = g ? b1 : a1;
        eo  = g ? o1 : o0;
        r   = alu_ref(eo, ex0, ex1);
        @(negedge clk);
        req_valid = pend;
        #1;
        check("exec_rsp_valid", {7'd0, rsp_valid}, 8'd0);
        check("exec_ready", {6'd0, req_ready}, 8'd0);
        check("exec_alu_ops", {alu_x0, alu_x1}, {ex0, ex1});
        check("exec_alu_ctr", {5'd0, alu_ctr}, {5'd0, eo});
        for (int i = 0; i <= hold; i++) begin
            @(negedge clk);
            check("resp_valid", {7'd0, rsp_valid}, 8'd1);
            check("resp_id", {7'd0, rsp_id}, {7'd0, g});
            check("resp_data", {3'd0, rsp_flg, rsp_result}, {3'd0, r});
            check("resp_ready_low", {6'd0, req_ready}, 8'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("idle_rsp_valid", {7'd0, rsp_valid}, 8'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 1'b0;
        {req0_x0, req0_x1, req0_op, req1_x0, req1_x1, req1_op} = '0;
        #1;
        check("rst_ready", {6'd0, req_ready}, 8'd0);
        check("rst_rsp", {2'd0, rsp_valid, rsp_id, rsp_flg, 3'd0}, 8'd0);
        check("rst_result", {4'd0, rsp_result}, 8'd0);
        check("rst_alu", {alu_x0, alu_x1}, 8'd0);
        check("rst_ctr", {5'd0, alu_ctr}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("idle_no_valid", {6'd0, req_ready}, 8'd0);

        // Requester 0 add, requester 1 signed-less-than and equal
        do_op(2'b01, 4'd3, 4'd5, 3'd0, 4'd0, 4'd0, 3'd0, 2'b00, 0);
        do_op(2'b10, 4'd0, 4'd0, 3'd0, 4'b1000, 4'd1, 3'd6, 2'b00, 0);
        do_op(2'b10, 4'd0, 4'd0, 3'd0, 4'd9, 4'd9, 3'd7, 2'b00, 0);

        // Both requesters held valid continuously
        for (int i = 0; i < 4; i++)
            do_op(2'b11, 4'(i), 4'd2, 3'd1, 4'd7, 4'(i), 3'd5, 2'b11, 0);

        // Backpressure for five cycles
        do_op(2'b01, 4'd12, 4'd10, 3'd3, 4'd0, 4'd0, 3'd0, 2'b01, 5);

        // Requester 0 withdraws before being granted while requester 1 stays valid
        do_op(2'b01, 4'd1, 4'd1, 3'd4, 4'd0, 4'd0, 3'd0, 2'b11, 1);
        do_op(2'b10, 4'd1, 4'd1, 3'd4, 4'd6, 4'd9, 3'd2, 2'b00, 0);

        // Reset asserted during EXEC of an xor
        req_valid = 2'b01;
        req0_x0 = 4'd6; req0_x1 = 4'd3; req0_op = 3'd5;
        #1;
        check("rst_test_accept", {6'd0, req_ready}, 8'd1);
        @(negedge clk);
        req_valid = 2'b00;
        rst_n = 1'b0;
        last_g = 1'b1;
        #1;
        check("midrst_rsp", {2'd0, rsp_valid, rsp_id, rsp_flg, 3'd0}, 8'd0);
        check("midrst_result", {4'd0, rsp_result}, 8'd0);
        check("midrst_alu", {alu_x0, alu_x1}, 8'd0);
        check("midrst_ctr", {5'd0, alu_ctr}, 8'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midrst_no_rsp", {7'd0, rsp_valid}, 8'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("postrst_no_rsp", {7'd0, rsp_valid}, 8'd0);
        do_op(2'b11, 4'd6, 4'd3, 3'd5, 4'd2, 4'd2, 3'd7, 2'b00, 0);

        // Randomized traffic
        for (int i = 0; i < 24; i++)
            do_op(2'($urandom_range(1, 3)),
                  4'($urandom), 4'($urandom), 3'($urandom),
                  4'($urandom), 4'($urandom), 3'($urandom),
                  2'($urandom_range(0, 3)), int'($urandom_range(0, 2)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
